riscv_operand_stage: RTL and testbench
======================================

Name: riscv_operand_stage

Overview:
- Parametrised successor to the single-operand select mux.
- Selects both ALU operands (op1, op2) and the store-data operand, with register forwarding from NUM_FWD later pipeline stages.
- Detects load-use hazards and stalls.
- Registers the results into a valid/ready pipeline stage between decode and execute.

Parameters:
- XLEN, 32, datapath width in bits.
- NUM_FWD, 3, number of forwarding sources; index 0 is the youngest and has the highest priority.
- REG_ADDR_W, 5, register address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  decode presents a valid instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- op1_sel  in  OP1_SEL  values OP1_RS1, OP1_PC, OP1_ZERO.
- op2_sel  in  OP2_SEL  values OP2_RS2, OP2_IMM, OP2_FOUR.
- rs2_used  in  1  rs2 is needed as store data, independent of op2_sel.
- rs1_addr, rs2_addr  in  REG_ADDR_W  source register addresses.
- rs1_data, rs2_data  in  XLEN  register file read data.
- pc, imm  in  XLEN  program counter and decoded immediate.
- fwd_valid  in  NUM_FWD  source i holds a register write.
- fwd_pending  in  NUM_FWD  source i result is not yet available (load in flight).
- fwd_rd  in  NUM_FWD*REG_ADDR_W  destination register per source.
- fwd_data  in  NUM_FWD*XLEN  result per source.
- flush  in  1  kill the registered and incoming instruction.
- out_valid  out  1  registered operands are valid.
- out_ready  in  1  execute consumes them.
- op1, op2, store_data  out  XLEN  registered operands.
- hazard_stall  out  1  load-use stall is active (combinational).

Behaviour:
- **Operand use:**
  - rs1 is used iff op1_sel==OP1_RS1.
  - rs2 is used iff op2_sel==OP2_RS2 or rs2_used.
- **Forward match for rs_x:**
  - Source i matches when fwd_valid[i] && fwd_rd[i]==rs_x_addr && rs_x_addr!=0.
  - The lowest matching index wins.
  - With no match, register file data is used.
  - x0 always reads as the register file value and is never forwarded.
- **hazard_stall:** asserted when, for a used operand, the winning match has fwd_pending=1. A pending source that is shadowed by a younger non-pending match does not stall.
- **Operand select:**
  - op1 = resolved rs1, pc, or 0.
  - op2 = resolved rs2, imm, or 32'd4 (zero-extended to XLEN).
  - store_data = resolved rs2.
  - Any undefined enum encoding selects 0.
- **Handshake:**
  - in_ready = !hazard_stall && !flush && (!out_valid || out_ready).
  - A transfer occurs when in_valid && in_ready.
  - On a transfer, next cycle: out_valid=1 and op1/op2/store_data are loaded. Latency is 1 cycle.
  - When out_valid && out_ready with no new transfer, out_valid falls to 0 and the data registers hold their value.
  - While out_valid && !out_ready, the outputs are held stable.
- **Stall:** while hazard_stall=1, no capture occurs. If execute consumes the current entry during the stall, out_valid falls to 0 (bubble).
- **Flush:** dominates everything. Next cycle out_valid=0, no capture that cycle, data registers hold.
- **Reset:** out_valid=0, op1=op2=store_data=0. Asserting reset mid-transfer discards the instruction. Operation resumes on the first edge after deassertion.
- **Simultaneous consume and accept:** the register takes the new data and out_valid stays 1 (full throughput, one instruction per cycle).

Decomposition:
- Shared package riscv_constants holds the OP1_SEL enum (OP1_RS1, OP1_PC, OP1_ZERO) and the OP2_SEL enum (OP2_RS2, OP2_IMM, OP2_FOUR).
- One sub-module, riscv_fwd_resolve, is instantiated twice (rs1, rs2). It is a combinational priority match that outputs the resolved data and a pending flag.
- Select logic and the pipeline register stay in the top module.

Test Plan:
- **Plain select:** op1_sel=OP1_PC, pc=0x100, op2_sel=OP2_IMM, imm=0x10, no forwarding, out_ready=1 -> next cycle out_valid=1, op1=0x100, op2=0x10.
- **Forward priority:** rs1_addr=5, fwd_valid=3'b110, fwd_rd[1]=5, fwd_rd[2]=5, fwd_data[1]=0xAA, fwd_data[2]=0xBB -> op1=0xAA. Repeat with rs1_addr=0 -> op1 takes rs1_data.
- **Load-use stall:** fwd_valid[0]=1, fwd_pending[0]=1, fwd_rd[0]=7, rs2_addr=7, rs2_used=1:
  - hazard_stall=1, in_ready=0, out_valid falls to 0 after consume.
  - Drop pending with fwd_data[0]=0x55 -> capture, store_data=0x55.
  - Same scenario with op2_sel=OP2_IMM and rs2_used=0 -> no stall.
- **Backpressure:** out_ready=0 for 3 cycles while in_valid=1 -> in_ready=0 and outputs stable. Raise out_ready -> back-to-back transfers, one per cycle.
- **Flush:** flush=1 with in_valid=1, out_valid=1 -> next cycle out_valid=0 and nothing captured.
- **Reset:** assert rst mid-stream, asynchronously between edges -> out_valid=0 and all operands 0 immediately. The first transfer after deassertion is correct.

Source files
------------

// File: rtl/riscv_constants.sv
// Operand-select encodings shared by decode and the operand stage.
// Latency: n/a (types only).
// Backpressure: n/a.
package riscv_constants;

  // Source for ALU operand 1; encoding 2'd3 is undefined and yields zero.
  typedef enum logic [1:0] {
    OP1_RS1  = 2'd0,
    OP1_PC   = 2'd1,
    OP1_ZERO = 2'd2
  } op1_sel_t;

  // Source for ALU operand 2; encoding 2'd3 is undefined and yields zero.
  typedef enum logic [1:0] {
    OP2_RS2  = 2'd0,
    OP2_IMM  = 2'd1,
    OP2_FOUR = 2'd2
  } op2_sel_t;

endpackage

// File: rtl/riscv_fwd_resolve.sv
// Resolves one source register against the forwarding sources (lowest index wins).
// Latency: combinational.
// Backpressure: none; flags a pending (load in flight) winner via rs_pending.
module riscv_fwd_resolve #(
  parameter int XLEN       = 32,
  parameter int NUM_FWD    = 3,
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0]         rs_addr,
  input  logic [XLEN-1:0]               rf_data,
  input  logic [NUM_FWD-1:0]            fwd_valid,
  input  logic [NUM_FWD-1:0]            fwd_pending,
  input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_rd,
  input  logic [NUM_FWD*XLEN-1:0]       fwd_data,
  output logic [XLEN-1:0]               rs_data,
  output logic                          rs_pending
);

  // Scan oldest to youngest so the youngest (lowest index) match overwrites; x0 never forwards.
  always_comb begin
    rs_data    = rf_data;
    rs_pending = 1'b0;
    if (rs_addr != '0) begin
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
        if (fwd_valid[i] && (fwd_rd[i*REG_ADDR_W +: REG_ADDR_W] == rs_addr)) begin
          rs_data    = fwd_data[i*XLEN +: XLEN];
          rs_pending = fwd_pending[i];
        end
      end
    end
  end

endmodule

// File: rtl/riscv_operand_stage.sv
// Selects op1/op2/store_data with forwarding and registers them between decode and execute.
// Latency: 1 cycle from accepted input to out_valid.
// Backpressure: in_ready drops on load-use stall, flush, or a held output not consumed.
module riscv_operand_stage
  import riscv_constants::*;
#(
  parameter int XLEN       = 32,
  parameter int NUM_FWD    = 3,
  parameter int REG_ADDR_W = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  op1_sel_t                      op1_sel,
  input  op2_sel_t                      op2_sel,
  input  logic                          rs2_used,
  input  logic [REG_ADDR_W-1:0]         rs1_addr,
  input  logic [REG_ADDR_W-1:0]         rs2_addr,
  input  logic [XLEN-1:0]               rs1_data,
  input  logic [XLEN-1:0]               rs2_data,
  input  logic [XLEN-1:0]               pc,
  input  logic [XLEN-1:0]               imm,
  input  logic [NUM_FWD-1:0]            fwd_valid,
  input  logic [NUM_FWD-1:0]            fwd_pending,
  input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_rd,
  input  logic [NUM_FWD*XLEN-1:0]       fwd_data,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [XLEN-1:0]               op1,
  output logic [XLEN-1:0]               op2,
  output logic [XLEN-1:0]               store_data,
  output logic                          hazard_stall
);

  logic [XLEN-1:0] rs1_res;
  logic [XLEN-1:0] rs2_res;
  logic            rs1_pend;
  logic            rs2_pend;
  logic            rs1_use;
  logic            rs2_use;
  logic [XLEN-1:0] op1_nxt;
  logic [XLEN-1:0] op2_nxt;
  logic            xfer;

  riscv_fwd_resolve #(
    .XLEN       (XLEN),
    .NUM_FWD    (NUM_FWD),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_rs1 (
    .rs_addr     (rs1_addr),
    .rf_data     (rs1_data),
    .fwd_valid   (fwd_valid),
    .fwd_pending (fwd_pending),
    .fwd_rd      (fwd_rd),
    .fwd_data    (fwd_data),
    .rs_data     (rs1_res),
    .rs_pending  (rs1_pend)
  );

  riscv_fwd_resolve #(
    .XLEN       (XLEN),
    .NUM_FWD    (NUM_FWD),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_rs2 (
    .rs_addr     (rs2_addr),
    .rf_data     (rs2_data),
    .fwd_valid   (fwd_valid),
    .fwd_pending (fwd_pending),
    .fwd_rd      (fwd_rd),
    .fwd_data    (fwd_data),
    .rs_data     (rs2_res),
    .rs_pending  (rs2_pend)
  );

  // Stall only when an operand actually consumed by this instruction waits on a load.
  always_comb begin
    rs1_use      = (op1_sel == OP1_RS1);
    rs2_use      = (op2_sel == OP2_RS2) || rs2_used;
    hazard_stall = (rs1_use && rs1_pend) || (rs2_use && rs2_pend);
    in_ready     = !hazard_stall && !flush && (!out_valid || out_ready);
    xfer         = in_valid && in_ready;
  end

  // Operand muxes; undefined encodings fall through to zero.
  always_comb begin
    op1_nxt = '0;
    op2_nxt = '0;
    case (op1_sel)
      OP1_RS1:  op1_nxt = rs1_res;
      OP1_PC:   op1_nxt = pc;
      OP1_ZERO: op1_nxt = '0;
      default:  op1_nxt = '0;
    endcase
    case (op2_sel)
      OP2_RS2:  op2_nxt = rs2_res;
      OP2_IMM:  op2_nxt = imm;
      OP2_FOUR: op2_nxt = XLEN'(4);
      default:  op2_nxt = '0;
    endcase
  end

  // Valid flag: flush kills, accept sets, consume without accept clears, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Operand registers load only on an accepted transfer and hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op1        <= '0;
      op2        <= '0;
      store_data <= '0;
    end else if (xfer) begin
      op1        <= op1_nxt;
      op2        <= op2_nxt;
      store_data <= rs2_res;
    end
  end

endmodule

// File: tb/tb_riscv_operand_stage.sv
// Directed bench for riscv_operand_stage with hand-computed expectations.
// Latency: checks outputs 1 ns after each rising edge.
// Backpressure: exercises stall, out_ready hold and flush paths.
module tb_riscv_operand_stage;
  import riscv_constants::*;

  localparam int XLEN = 32;
  localparam int NF   = 3;
  localparam int RW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  op1_sel_t        op1_sel;
  op2_sel_t        op2_sel;
  logic            rs2_used;
  logic [RW-1:0]   rs1_addr;
  logic [RW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic [NF-1:0]   fwd_valid;
  logic [NF-1:0]   fwd_pending;
  logic [NF*RW-1:0]   fwd_rd;
  logic [NF*XLEN-1:0] fwd_data;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [XLEN-1:0] store_data;
  logic            hazard_stall;

  int errors = 0;
  int checks = 0;

  riscv_operand_stage #(.XLEN(XLEN), .NUM_FWD(NF), .REG_ADDR_W(RW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .op1_sel      (op1_sel),
    .op2_sel      (op2_sel),
    .rs2_used     (rs2_used),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .pc           (pc),
    .imm          (imm),
    .fwd_valid    (fwd_valid),
    .fwd_pending  (fwd_pending),
    .fwd_rd       (fwd_rd),
    .fwd_data     (fwd_data),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .op1          (op1),
    .op2          (op2),
    .store_data   (store_data),
    .hazard_stall (hazard_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fwd(input int i, input logic [RW-1:0] rd, input logic [XLEN-1:0] d);
    fwd_rd[i*RW +: RW]       = rd;
    fwd_data[i*XLEN +: XLEN] = d;
  endtask

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    op1_sel     = OP1_ZERO;
    op2_sel     = OP2_FOUR;
    rs2_used    = 1'b0;
    rs1_addr    = '0;
    rs2_addr    = '0;
    rs1_data    = '0;
    rs2_data    = '0;
    pc          = '0;
    imm         = '0;
    fwd_valid   = '0;
    fwd_pending = '0;
    fwd_rd      = '0;
    fwd_data    = '0;
    flush       = 1'b0;
    out_ready   = 1'b1;

    // Reset state
    tick();
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_op1", op1, 32'h0);
    chk("rst_op2", op2, 32'h0);
    chk("rst_store", store_data, 32'h0);
    rst = 1'b0;

    // Plain select: PC and immediate
    op1_sel  = OP1_PC;
    pc       = 32'h100;
    op2_sel  = OP2_IMM;
    imm      = 32'h10;
    rs2_data = 32'h22;
    in_valid = 1'b1;
    #1;
    chk1("plain_in_ready", in_ready, 1'b1);
    chk1("plain_no_stall", hazard_stall, 1'b0);
    tick();
    in_valid = 1'b0;
    chk1("plain_out_valid", out_valid, 1'b1);
    chk("plain_op1", op1, 32'h100);
    chk("plain_op2", op2, 32'h10);
    chk("plain_store", store_data, 32'h22);
    tick();
    chk1("drain_out_valid", out_valid, 1'b0);
    chk("drain_op1_hold", op1, 32'h100);

    // Forward priority: sources 1 and 2 both write x5, source 1 wins
    op1_sel   = OP1_RS1;
    rs1_addr  = 5'd5;
    rs1_data  = 32'h11;
    op2_sel   = OP2_FOUR;
    fwd_valid = 3'b110;
    set_fwd(1, 5'd5, 32'hAA);
    set_fwd(2, 5'd5, 32'hBB);
    in_valid  = 1'b1;
    tick();
    chk("fwd_prio_op1", op1, 32'hAA);
    chk("fwd_four_op2", op2, 32'h4);
    rs1_addr = 5'd0;
    tick();
    chk("fwd_x0_op1", op1, 32'h11);
    rs1_addr  = 5'd5;
    fwd_valid = 3'b100;
    tick();
    chk("fwd_src2_op1", op1, 32'hBB);
    op1_sel = op1_sel_t'(2'd3);
    op2_sel = op2_sel_t'(2'd3);
    tick();
    chk("undef_op1", op1, 32'h0);
    chk("undef_op2", op2, 32'h0);
    chk1("undef_out_valid", out_valid, 1'b1);

    // Load-use stall on rs2 used as store data
    op1_sel     = OP1_ZERO;
    op2_sel     = OP2_IMM;
    imm         = 32'h3;
    rs2_used    = 1'b1;
    rs2_addr    = 5'd7;
    rs2_data    = 32'h99;
    fwd_valid   = 3'b001;
    fwd_pending = 3'b001;
    set_fwd(0, 5'd7, 32'h44);
    #1;
    chk1("lu_stall", hazard_stall, 1'b1);
    chk1("lu_in_ready", in_ready, 1'b0);
    tick();
    chk1("lu_bubble", out_valid, 1'b0);
    chk("lu_op2_hold", op2, 32'h0);
    fwd_pending = 3'b000;
    set_fwd(0, 5'd7, 32'h55);
    #1;
    chk1("lu_release_stall", hazard_stall, 1'b0);
    chk1("lu_release_ready", in_ready, 1'b1);
    tick();
    chk1("lu_cap_valid", out_valid, 1'b1);
    chk("lu_cap_store", store_data, 32'h55);
    chk("lu_cap_op2", op2, 32'h3);

    // Pending source 1 shadowed by non-pending source 0
    fwd_valid   = 3'b011;
    fwd_pending = 3'b010;
    set_fwd(0, 5'd7, 32'h66);
    set_fwd(1, 5'd7, 32'h77);
    #1;
    chk1("shadow_no_stall", hazard_stall, 1'b0);
    tick();
    chk("shadow_store", store_data, 32'h66);
    fwd_pending = 3'b001;
    #1;
    chk1("young_pending_stall", hazard_stall, 1'b1);

    // rs2 not used: pending match is ignored
    rs2_used = 1'b0;
    #1;
    chk1("unused_no_stall", hazard_stall, 1'b0);
    chk1("unused_in_ready", in_ready, 1'b1);
    tick();
    chk1("unused_valid", out_valid, 1'b1);
    chk("unused_op2", op2, 32'h3);

    // x0 never matches a pending source
    op1_sel  = OP1_RS1;
    rs1_addr = 5'd0;
    set_fwd(0, 5'd0, 32'hDEAD);
    #1;
    chk1("x0_no_stall", hazard_stall, 1'b0);
    tick();
    chk("x0_op1", op1, 32'h11);

    // Backpressure for three cycles, then back-to-back transfers
    fwd_valid   = '0;
    fwd_pending = '0;
    out_ready   = 1'b0;
    op1_sel     = OP1_PC;
    pc          = 32'h200;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk1("bp_in_ready", in_ready, 1'b0);
      tick();
      chk1("bp_valid", out_valid, 1'b1);
      chk("bp_op1_hold", op1, 32'h11);
    end
    out_ready = 1'b1;
    #1;
    chk1("bp_release_ready", in_ready, 1'b1);
    tick();
    chk("b2b_op1_0", op1, 32'h200);
    pc = 32'h204;
    tick();
    chk("b2b_op1_1", op1, 32'h204);
    chk1("b2b_valid_1", out_valid, 1'b1);
    pc = 32'h208;
    tick();
    chk("b2b_op1_2", op1, 32'h208);
    chk1("b2b_valid_2", out_valid, 1'b1);

    // Flush kills held and incoming instruction
    flush = 1'b1;
    pc    = 32'h300;
    #1;
    chk1("flush_in_ready", in_ready, 1'b0);
    tick();
    chk1("flush_valid", out_valid, 1'b0);
    chk("flush_op1_hold", op1, 32'h208);
    flush = 1'b0;

    // Asynchronous reset mid-stream
    pc = 32'h400;
    tick();
    chk("pre_rst_op1", op1, 32'h400);
    chk1("pre_rst_valid", out_valid, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    chk1("async_rst_valid", out_valid, 1'b0);
    chk("async_rst_op1", op1, 32'h0);
    chk("async_rst_op2", op2, 32'h0);
    chk("async_rst_store", store_data, 32'h0);
    pc      = 32'h500;
    op2_sel = OP2_IMM;
    imm     = 32'h7;
    tick();
    chk1("held_rst_valid", out_valid, 1'b0);
    rst = 1'b0;
    tick();
    chk1("post_rst_valid", out_valid, 1'b1);
    chk("post_rst_op1", op1, 32'h500);
    chk("post_rst_op2", op2, 32'h7);
    in_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
